// File: rtl/rom_fetch_pkg.sv
// Shared constants and types for the ROM fetch path and the instruction-mode selector.
package rom_fetch_pkg;

  localparam int          DEF_ADDR_W    = 10;
  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] I_WAIT_STAY   = 32'h0000_0013;
  localparam logic        ROM_INST_SEL  = 1'b1;
  localparam logic        RESET         = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HALT
  } state_t;

endpackage

// File: rtl/rom_fetch_if.sv
// Control, ROM and issue signals between rom_fetch (slave) and its surroundings (master).
interface rom_fetch_if
  import rom_fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              mode_sel;
  logic              start;
  logic              jump_valid;
  logic [ADDR_W-1:0] jump_addr;
  logic [31:0]       rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_en;
  logic [31:0]       rom_inst;
  logic [1:0]        slot;
  logic [ADDR_W-1:0] pc;
  logic              halted;

  modport master (
    output mode_sel, start, jump_valid, jump_addr, rom_data,
    input  rom_addr, rom_en, rom_inst, slot, pc, halted
  );

  modport slave (
    input  mode_sel, start, jump_valid, jump_addr, rom_data,
    output rom_addr, rom_en, rom_inst, slot, pc, halted
  );
endinterface

// File: rtl/rom_slot_counter.sv
// 2-bit issue-slot counter; the instruction-mode selector instantiates the same block
// with the same clear/enable so both ends stay cycle-aligned.
module rom_slot_counter
  import rom_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst_n == RESET || clr) cnt <= 2'd0;
    else if (en)               cnt <= cnt + 2'd1;
  end

endmodule

// File: rtl/rom_fetch.sv
// ROM instruction fetcher: one ROM read per 4-cycle issue slot, one delay slot after jumps.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | after reset; no reads, jump_valid only loads pc
//   ST_FETCH | slot 1 read, slot 2 capture, 3->0 issue and pc advance
//   ST_HALT  | halt word was issued; no reads until start or jump
module rom_fetch
  import rom_fetch_pkg::*;
#(
  parameter int          ADDR_W    = DEF_ADDR_W,
  parameter logic [31:0] HALT_WORD = DEF_HALT_WORD
)(
  input  logic         clk,
  input  logic         rst_n,
  rom_fetch_if.slave   bus
);

  state_t            state, state_nxt;
  logic [1:0]        slot;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pend_addr;
  logic              pend_valid;
  logic [31:0]       prefetch;
  logic [31:0]       inst;
  logic              rom_mode, halt_hit, run, issue, rom_en;

  assign rom_mode = (bus.mode_sel == ROM_INST_SEL);
  assign halt_hit = (state == ST_FETCH) && (inst == HALT_WORD);
  assign run      = (state == ST_FETCH) && rom_mode && !halt_hit;
  assign issue    = run && (slot == 2'd3);

  // Leaving ROM mode or halting clears the slot, so a half-done read is simply redone.
  rom_slot_counter u_slot (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!run),
    .en    (run),
    .cnt   (slot)
  );

  always_ff @(posedge clk) begin
    if (rst_n == RESET) state <= ST_IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rom_en    = 1'b0;
    case (state)
      ST_IDLE:  if (bus.start) state_nxt = ST_FETCH;
      ST_FETCH: begin
        rom_en = run && (slot == 2'd1);
        if (halt_hit) state_nxt = ST_HALT;
      end
      ST_HALT:  if (bus.start || bus.jump_valid) state_nxt = ST_FETCH;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n == RESET) begin
      pc         <= '0;
      pend_addr  <= '0;
      pend_valid <= 1'b0;
      prefetch   <= '0;
      inst       <= I_WAIT_STAY;
    end else begin
      if (run && slot == 2'd2) prefetch <= bus.rom_data;

      if (halt_hit) begin
        inst       <= I_WAIT_STAY;
        pend_valid <= 1'b0;
      end else if (state != ST_FETCH) begin
        pend_valid <= 1'b0;
        if (bus.jump_valid) pc <= bus.jump_addr;
      end else if (issue) begin
        inst       <= prefetch;
        pend_valid <= 1'b0;
        // A request on the issue edge itself is newer than anything pending.
        if (bus.jump_valid)  pc <= bus.jump_addr;
        else if (pend_valid) pc <= pend_addr;
        else                 pc <= pc + 1'b1;
      end else if (bus.jump_valid) begin
        pend_valid <= 1'b1;
        pend_addr  <= bus.jump_addr;
      end
    end
  end

  assign bus.rom_addr = pc;
  assign bus.rom_en   = rom_en;
  assign bus.rom_inst = inst;
  assign bus.slot     = slot;
  assign bus.pc       = pc;
  assign bus.halted   = (state == ST_HALT);

endmodule
